// File: rtl/sdram_cmd_regbank.sv
// sdram_cmd_regbank
//
// Multi-channel SDRAM command register bank. Host writes, qualified by the
// active-low chip select, go into one pending slot per channel. A round-robin
// arbiter hands the pending slots one at a time to the SDRAM engine over a
// valid/ready/done handshake. FIFO-clear requests are stretched into pulses
// CLR_LEN cycles long.
//
// Optional feature macro: SDRAM_CMD_RANGE_CHECK_EN
//   defined   -> commands with addr_end < addr_begin are rejected (host_err)
//   undefined -> no address compare is built; any begin/end pair is accepted
//
// Ports:
//   clk, reset_n          clock (rising edge) and async active-low reset
//   cs                    active-low chip select for all host inputs
//   ch_sel                target channel of a host write
//   wr_sdram, rd_sdram    write / read command request
//   addr_begin, addr_end  inclusive address range of the command
//   pre_fifoclr,
//   post_fifoclr          FIFO-clear requests
//   host_ack, host_err    one-cycle accept / reject pulses
//   slot_pending          per-channel pending flags
//   busy                  arbiter FSM is not idle
//   cmd_valid, cmd_ready,
//   cmd_done              command handshake to the SDRAM engine
//   cmd_ch, cmd_wr,
//   cmd_begin, cmd_end    fields of the offered command
//   pre_fifoclr_out,
//   post_fifoclr_out      stretched FIFO-clear pulses
module sdram_cmd_regbank #(
   parameter int NCH = 4,
   parameter int ADDR_W = 16,
   parameter int CLR_LEN = 4,
   localparam int CH_W = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cs,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              wr_sdram,
   input  logic              rd_sdram,
   input  logic [ADDR_W-1:0] addr_begin,
   input  logic [ADDR_W-1:0] addr_end,
   input  logic              pre_fifoclr,
   input  logic              post_fifoclr,
   output logic              host_ack,
   output logic              host_err,
   output logic [NCH-1:0]    slot_pending,
   output logic              busy,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   input  logic              cmd_done,
   output logic [CH_W-1:0]   cmd_ch,
   output logic              cmd_wr,
   output logic [ADDR_W-1:0] cmd_begin,
   output logic [ADDR_W-1:0] cmd_end,
   output logic              pre_fifoclr_out,
   output logic              post_fifoclr_out
);

   localparam int CNT_W = $clog2(CLR_LEN + 1);
   localparam logic [CH_W:0] NCH_V = (CH_W + 1)'(NCH);
   localparam logic [CNT_W-1:0] CLR_V = CNT_W'(CLR_LEN);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

   state_t state, next_state;

   logic              slot_wr    [NCH];
   logic [ADDR_W-1:0] slot_begin [NCH];
   logic [ADDR_W-1:0] slot_end   [NCH];

   logic [CH_W-1:0]  ptr;
   logic [CNT_W-1:0] pre_cnt, post_cnt;

   logic            host_req, ch_bad, occupied, range_bad, reject, accept;
   logic            found, handshake;
   logic [CH_W-1:0] pick;
   logic [CH_W:0]   cand_sum, ptr_inc;

`ifdef SDRAM_CMD_RANGE_CHECK_EN
   assign range_bad = (addr_end < addr_begin);
`else
   assign range_bad = 1'b0;
`endif

   // Host command qualification. The registered pending flag is used, so a
   // slot that is being granted this very cycle still rejects a new write.
   always_comb begin
      host_req = ~cs & (wr_sdram | rd_sdram);
      ch_bad   = ({1'b0, ch_sel} >= NCH_V);
      occupied = ch_bad ? 1'b0 : slot_pending[ch_sel];
      reject   = host_req & ((wr_sdram & rd_sdram) | ch_bad | occupied | range_bad);
      accept   = host_req & ~reject;
   end

   // Round-robin search: first pending channel at or above the pointer,
   // wrapping from NCH-1 back to 0.
   always_comb begin
      found    = 1'b0;
      pick     = '0;
      cand_sum = '0;
      for (int i = 0; i < NCH; i++) begin
         cand_sum = {1'b0, ptr} + (CH_W + 1)'(i);
         if (cand_sum >= NCH_V) cand_sum = cand_sum - NCH_V;
         if (!found && slot_pending[cand_sum[CH_W-1:0]]) begin
            found = 1'b1;
            pick  = cand_sum[CH_W-1:0];
         end
      end
   end

   // Arbiter FSM next-state logic; only one command may be outstanding.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:      if (found)     next_state = ISSUE;
         ISSUE:     if (cmd_ready) next_state = WAIT_DONE;
         WAIT_DONE: if (cmd_done)  next_state = IDLE;
         default:                  next_state = IDLE;
      endcase
   end

   assign handshake = (state == ISSUE) & cmd_ready;
   assign cmd_valid = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign ptr_inc   = {1'b0, cmd_ch} + (CH_W + 1)'(1);

   // FSM state, round-robin pointer and the registered command fields.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         ptr       <= '0;
         cmd_ch    <= '0;
         cmd_wr    <= 1'b0;
         cmd_begin <= '0;
         cmd_end   <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && found) begin
            cmd_ch    <= pick;
            cmd_wr    <= slot_wr[pick];
            cmd_begin <= slot_begin[pick];
            cmd_end   <= slot_end[pick];
         end
         if (handshake)
            ptr <= (ptr_inc == NCH_V) ? '0 : ptr_inc[CH_W-1:0];
      end
   end

   // Slot storage and host response pulses. A grant and an accept can never
   // target the same channel: accept needs the slot empty, grant needs it full.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         host_ack     <= 1'b0;
         host_err     <= 1'b0;
         slot_pending <= '0;
         for (int i = 0; i < NCH; i++) begin
            slot_wr[i]    <= 1'b0;
            slot_begin[i] <= '0;
            slot_end[i]   <= '0;
         end
      end else begin
         host_ack <= accept;
         host_err <= reject;
         if (handshake) slot_pending[cmd_ch] <= 1'b0;
         if (accept) begin
            slot_pending[ch_sel] <= 1'b1;
            slot_wr[ch_sel]      <= wr_sdram;
            slot_begin[ch_sel]   <= addr_begin;
            slot_end[ch_sel]     <= addr_end;
         end
      end
   end

   // FIFO-clear stretchers; a new request reloads the counter (retrigger).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt  <= '0;
         post_cnt <= '0;
      end else begin
         if (!cs && pre_fifoclr)  pre_cnt <= CLR_V;
         else if (pre_cnt != '0)  pre_cnt <= pre_cnt - 1'b1;
         if (!cs && post_fifoclr) post_cnt <= CLR_V;
         else if (post_cnt != '0) post_cnt <= post_cnt - 1'b1;
      end
   end

   assign pre_fifoclr_out  = (pre_cnt != '0);
   assign post_fifoclr_out = (post_cnt != '0);

endmodule

// File: tb/tb_sdram_cmd_regbank.sv
// tb_sdram_cmd_regbank
//
// Testbench for sdram_cmd_regbank (default parameters NCH=4, ADDR_W=16,
// CLR_LEN=4). A transaction-level reference model tracks the slots, the
// grant pointer, the outstanding command and the clear timers, and every
// cycle's outputs are compared against it. Directed sequences cover the
// listed scenarios; a long randomized run exercises everything together.
// Honors SDRAM_CMD_RANGE_CHECK_EN in the same way as the design.
module tb_sdram_cmd_regbank;

   localparam int NCH = 4;
   localparam int ADDR_W = 16;
   localparam int CLR_LEN = 4;
   localparam int CH_W = 2;

`ifdef SDRAM_CMD_RANGE_CHECK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cs = 1'b1;
   logic [CH_W-1:0]   ch_sel = '0;
   logic              wr_sdram = 1'b0;
   logic              rd_sdram = 1'b0;
   logic [ADDR_W-1:0] addr_begin = '0;
   logic [ADDR_W-1:0] addr_end = '0;
   logic              pre_fifoclr = 1'b0;
   logic              post_fifoclr = 1'b0;
   logic              cmd_ready = 1'b0;
   logic              cmd_done = 1'b0;
   logic              host_ack, host_err, busy, cmd_valid, cmd_wr;
   logic [NCH-1:0]    slot_pending;
   logic [CH_W-1:0]   cmd_ch;
   logic [ADDR_W-1:0] cmd_begin, cmd_end;
   logic              pre_fifoclr_out, post_fifoclr_out;

   sdram_cmd_regbank #(.NCH(NCH), .ADDR_W(ADDR_W), .CLR_LEN(CLR_LEN)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .ch_sel(ch_sel),
      .wr_sdram(wr_sdram), .rd_sdram(rd_sdram),
      .addr_begin(addr_begin), .addr_end(addr_end),
      .pre_fifoclr(pre_fifoclr), .post_fifoclr(post_fifoclr),
      .host_ack(host_ack), .host_err(host_err), .slot_pending(slot_pending),
      .busy(busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_done(cmd_done), .cmd_ch(cmd_ch), .cmd_wr(cmd_wr),
      .cmd_begin(cmd_begin), .cmd_end(cmd_end),
      .pre_fifoclr_out(pre_fifoclr_out), .post_fifoclr_out(post_fifoclr_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // Reference model. outstanding: 0 = none, 1 = offered, 2 = accepted and
   // awaiting completion.
   bit m_pend [NCH];
   bit m_wr   [NCH];
   int m_beg  [NCH];
   int m_end  [NCH];
   int m_ptr, outstanding, m_ch, m_cwr, m_cbeg, m_cend;
   int m_ack, m_err, m_pre, m_post;

   task automatic checkOutput(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int packPend();
      int v = 0;
      for (int i = 0; i < NCH; i++) if (m_pend[i]) v |= (1 << i);
      return v;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < NCH; i++) begin
         m_pend[i] = 1'b0; m_wr[i] = 1'b0; m_beg[i] = 0; m_end[i] = 0;
      end
      m_ptr = 0; outstanding = 0; m_ch = 0; m_cwr = 0; m_cbeg = 0; m_cend = 0;
      m_ack = 0; m_err = 0; m_pre = 0; m_post = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit n_pend [NCH];
      bit req, bad;
      if (!reset_n) begin
         modelReset();
         return;
      end
      n_pend = m_pend;
      if (outstanding == 0) begin
         for (int i = 0; i < NCH; i++) begin
            int c = (m_ptr + i) % NCH;
            if (m_pend[c]) begin
               outstanding = 1; m_ch = c; m_cwr = m_wr[c];
               m_cbeg = m_beg[c]; m_cend = m_end[c];
               break;
            end
         end
      end else if (outstanding == 1) begin
         if (cmd_ready) begin
            n_pend[m_ch] = 1'b0;
            m_ptr = (m_ch + 1) % NCH;
            outstanding = 2;
         end
      end else if (cmd_done) begin
         outstanding = 0;
      end
      m_ack = 0; m_err = 0;
      req = !cs && (wr_sdram || rd_sdram);
      if (req) begin
         bad = (wr_sdram && rd_sdram) || (int'(ch_sel) >= NCH) || m_pend[ch_sel]
               || (RANGE_CHK && (addr_end < addr_begin));
         if (bad) m_err = 1;
         else begin
            m_ack = 1;
            n_pend[ch_sel] = 1'b1;
            m_wr[ch_sel] = wr_sdram;
            m_beg[ch_sel] = int'(addr_begin);
            m_end[ch_sel] = int'(addr_end);
         end
      end
      m_pend = n_pend;
      if (!cs && pre_fifoclr) m_pre = CLR_LEN; else if (m_pre > 0) m_pre--;
      if (!cs && post_fifoclr) m_post = CLR_LEN; else if (m_post > 0) m_post--;
   endtask

   task automatic compareAll();
      checkOutput("host_ack", host_ack, m_ack);
      checkOutput("host_err", host_err, m_err);
      checkOutput("slot_pending", slot_pending, packPend());
      checkOutput("busy", busy, int'(outstanding != 0));
      checkOutput("cmd_valid", cmd_valid, int'(outstanding == 1));
      checkOutput("cmd_ch", cmd_ch, m_ch);
      checkOutput("cmd_wr", cmd_wr, m_cwr);
      checkOutput("cmd_begin", cmd_begin, m_cbeg);
      checkOutput("cmd_end", cmd_end, m_cend);
      checkOutput("pre_fifoclr_out", pre_fifoclr_out, int'(m_pre > 0));
      checkOutput("post_fifoclr_out", post_fifoclr_out, int'(m_post > 0));
   endtask

   task automatic tick();
      modelStep();
      @(posedge clk);
      #1;
      compareAll();
   endtask

   task automatic applyStimulus(input bit c, input bit w, input bit r, input int ch,
                                input int b, input int e, input bit pr, input bit po);
      cs = c; wr_sdram = w; rd_sdram = r; ch_sel = CH_W'(ch);
      addr_begin = ADDR_W'(b); addr_end = ADDR_W'(e);
      pre_fifoclr = pr; post_fifoclr = po;
   endtask

   task automatic applyIdle();
      applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   // Serve the next offered command; bounded wait for cmd_valid.
   task automatic serveOne(output int ch, output int b, output int e);
      int w = 0;
      applyIdle();
      cmd_ready = 1'b0; cmd_done = 1'b0;
      while (!cmd_valid && w < 20) begin
         tick();
         w++;
      end
      checkOutput("serve_valid", cmd_valid, 1);
      ch = cmd_ch; b = cmd_begin; e = cmd_end;
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      cmd_done = 1'b1;  tick(); cmd_done = 1'b0;
   endtask

   task automatic drainAll();
      int w = 0;
      applyIdle();
      cmd_ready = 1'b1; cmd_done = 1'b1;
      while ((busy || slot_pending != '0) && w < 60) begin
         tick();
         w++;
      end
      cmd_ready = 1'b0; cmd_done = 1'b0;
      checkOutput("drain_idle", int'(busy || slot_pending != '0), 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int g, gb, ge, hi_pre, hi_post;
      int exp_order [4];
      exp_order = '{0, 1, 3, 0};
      modelReset();

      // Reset state, held across a few edges.
      #1;
      compareAll();
      applyIdle();
      repeat (3) tick();
      reset_n = 1'b1;

      // Single write on channel 2.
      applyStimulus(1'b0, 1'b1, 1'b0, 2, 'h0010, 'h00FF, 1'b0, 1'b0);
      tick();
      checkOutput("t1_ack", host_ack, 1);
      applyIdle();
      tick();
      checkOutput("t1_valid", cmd_valid, 1);
      checkOutput("t1_ch", cmd_ch, 2);
      checkOutput("t1_wr", cmd_wr, 1);
      checkOutput("t1_begin", cmd_begin, 'h0010);
      checkOutput("t1_end", cmd_end, 'h00FF);
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      checkOutput("t1_pend2", slot_pending[2], 0);
      checkOutput("t1_valid_drop", cmd_valid, 0);
      cmd_done = 1'b1; tick(); cmd_done = 1'b0;

      // Round-robin order, with channel 0 reloaded after its first grant.
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 'h0100, 'h01FF, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1, 'h0200, 'h02FF, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 3, 'h0300, 'h03FF, 1'b0, 1'b0); tick();
      for (int k = 0; k < 4; k++) begin
         serveOne(g, gb, ge);
         checkOutput($sformatf("rr_grant%0d", k), g, exp_order[k]);
         if (k == 0) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 0, 'h0400, 'h04FF, 1'b0, 1'b0);
            tick();
         end
      end
      drainAll();

      // Double load of channel 1: second is rejected, first is kept.
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 'h0020, 'h0030, 1'b0, 1'b0); tick();
      checkOutput("dbl_ack", host_ack, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1, 'h0040, 'h0050, 1'b0, 1'b0); tick();
      checkOutput("dbl_err", host_err, 1);
      serveOne(g, gb, ge);
      checkOutput("dbl_ch", g, 1);
      checkOutput("dbl_begin", gb, 'h0020);
      checkOutput("dbl_end", ge, 'h0030);
      drainAll();

      // Conflicting op and reversed range.
      applyStimulus(1'b0, 1'b1, 1'b1, 2, 'h0000, 'h0010, 1'b0, 1'b0); tick();
      checkOutput("both_err", host_err, 1);
      checkOutput("both_ack", host_ack, 0);
      checkOutput("both_pend", slot_pending, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 3, 'h0100, 'h00FF, 1'b0, 1'b0); tick();
      checkOutput("range_err", host_err, int'(RANGE_CHK));
      checkOutput("range_ack", host_ack, int'(!RANGE_CHK));
      drainAll();

      // FIFO-clear stretch and retrigger.
      hi_pre = 0;
      for (int t = 0; t < 8; t++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, (t == 0), 1'b0);
         tick();
         if (pre_fifoclr_out) hi_pre++;
      end
      checkOutput("clr_single_len", hi_pre, 4);
      hi_pre = 0; hi_post = 0;
      for (int t = 0; t < 12; t++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, (t == 0 || t == 3), (t == 1));
         tick();
         if (pre_fifoclr_out) hi_pre++;
         if (post_fifoclr_out) hi_post++;
      end
      checkOutput("clr_retrig_len", hi_pre, 7);
      checkOutput("clr_post_len", hi_post, 4);

      // Reset during WAIT_DONE with two slots pending.
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 'h0500, 'h05FF, 1'b1, 1'b0); tick();
      applyStimulus(1'b0, 1'b0, 1'b1, 1, 'h0600, 'h06FF, 1'b0, 1'b0); tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 2, 'h0700, 'h07FF, 1'b0, 1'b0); tick();
      applyIdle();
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      checkOutput("rst_pre_busy", busy, 1);
      checkOutput("rst_pre_pend", slot_pending, 'b0110);
      #2;
      reset_n = 1'b0;
      #1;
      modelReset();
      compareAll();
      checkOutput("rst_pend", slot_pending, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_clr", pre_fifoclr_out, 0);
      tick();
      reset_n = 1'b1;
      cmd_done = 1'b1; tick(); cmd_done = 1'b0;
      checkOutput("stray_done_busy", busy, 0);
      checkOutput("stray_done_valid", cmd_valid, 0);
      tick();

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         int b = $urandom_range(0, 65535);
         int e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                             : b + int'($urandom_range(0, 255));
         applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                       ($urandom_range(0, 2) == 0), int'($urandom_range(0, NCH - 1)),
                       b, e, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
         cmd_ready = ($urandom_range(0, 1) == 1);
         cmd_done = ($urandom_range(0, 3) == 0);
         tick();
      end
      drainAll();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
